// File: rtl/dump_ctrl.sv
// dump_ctrl: capture sequencer for analog probe channels sharing one dump sink.
// After a trigger it waits a programmable delay, then samples every (decim+1)
// cycles, granting one requesting channel per sampling edge in round-robin
// order, until n_samp grants have been made (n_samp=0 runs until abort).
// Optional feature macro: DUMP_CTRL_STAMP_EN builds the RUN-relative timestamp
// counter; without it stamp is tied to zero. The port list is the same either way.
//
// Sink handshake: dump_en is a one-cycle push with no back-pressure. While
// dump_en=1, ch_grant (one-hot) and ch_sel (binary) name the channel being
// dumped; the sink must accept in that cycle. There is no ready signal.
module dump_ctrl #(
   parameter int N_CH    = 4,
   parameter int DECIM_W = 16,
   parameter int CNT_W   = 32,
   localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               trig,
   input  logic               abort,
   input  logic [CNT_W-1:0]   delay,
   input  logic [DECIM_W-1:0] decim,
   input  logic [CNT_W-1:0]   n_samp,
   input  logic [N_CH-1:0]    ch_req,
   output logic               dump_en,
   output logic [N_CH-1:0]    ch_grant,
   output logic [SEL_W-1:0]   ch_sel,
   output logic [CNT_W-1:0]   sample_idx,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   stamp
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   dly_q, dly_d;
   logic [DECIM_W-1:0] dcnt_q, dcnt_d;
   logic [DECIM_W-1:0] decim_q, decim_d;
   logic [CNT_W-1:0]   nsamp_q, nsamp_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic               dump_en_q, dump_en_d;
   logic [N_CH-1:0]    grant_q, grant_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [N_CH-1:0]    req_hi;
   logic               win_vld;
   logic [SEL_W-1:0]   win_sel;
   logic [N_CH-1:0]    win_grant;
   logic [SEL_W-1:0]   ptr_nxt;
   logic [CNT_W-1:0]   idx_inc;

   // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
   always_comb begin
      req_hi    = '0;
      win_vld   = 1'b0;
      win_sel   = '0;
      win_grant = '0;
      for (int k = 0; k < N_CH; k++) begin
         req_hi[k] = ch_req[k] && (SEL_W'(k) >= ptr_q);
      end
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (ch_req[k]) begin
            win_vld = 1'b1;
            win_sel = SEL_W'(k);
         end
      end
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (req_hi[k]) begin
            win_sel = SEL_W'(k);
         end
      end
      for (int k = 0; k < N_CH; k++) begin
         win_grant[k] = (win_sel == SEL_W'(k));
      end
      ptr_nxt = (win_sel == SEL_W'(N_CH - 1)) ? '0 : win_sel + SEL_W'(1);
      idx_inc = idx_q + CNT_W'(1);
   end

   // Next-state and registered-output logic for the capture sequencer.
   always_comb begin
      state_d   = state_q;
      dly_d     = dly_q;
      dcnt_d    = dcnt_q;
      decim_d   = decim_q;
      nsamp_d   = nsamp_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      dump_en_d = 1'b0;
      grant_d   = '0;
      sel_d     = sel_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (trig) begin
               decim_d = decim;
               nsamp_d = n_samp;
               idx_d   = '0;
               ptr_d   = '0;
               dcnt_d  = '0;
               if (delay == '0) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_DELAY;
                  dly_d   = delay - CNT_W'(1);
               end
            end
         end
         S_DELAY: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (dly_q == '0) begin
               state_d = S_RUN;
               dcnt_d  = '0;
            end else begin
               dly_d = dly_q - CNT_W'(1);
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               dcnt_d = (dcnt_q == '0) ? decim_q : dcnt_q - DECIM_W'(1);
               if ((dcnt_q == '0) && win_vld) begin
                  dump_en_d = 1'b1;
                  grant_d   = win_grant;
                  sel_d     = win_sel;
                  ptr_d     = ptr_nxt;
                  idx_d     = idx_inc;
                  if ((nsamp_q != '0) && (idx_inc == nsamp_q)) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_DELAY) || (state_d == S_RUN);
   end

   // State and output registers; reset overrides trig and abort.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         dly_q     <= '0;
         dcnt_q    <= '0;
         decim_q   <= '0;
         nsamp_q   <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         dump_en_q <= 1'b0;
         grant_q   <= '0;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dly_q     <= dly_d;
         dcnt_q    <= dcnt_d;
         decim_q   <= decim_d;
         nsamp_q   <= nsamp_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         dump_en_q <= dump_en_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef DUMP_CTRL_STAMP_EN
   logic [CNT_W-1:0] stamp_q, stamp_d;

   // Timestamp: zero on RUN entry, count every RUN edge, hold elsewhere.
   always_comb begin
      stamp_d = stamp_q;
      if ((state_q != S_RUN) && (state_d == S_RUN)) begin
         stamp_d = '0;
      end else if (state_q == S_RUN) begin
         stamp_d = stamp_q + CNT_W'(1);
      end
   end

   // Timestamp register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stamp_q <= '0;
      end else begin
         stamp_q <= stamp_d;
      end
   end

   assign stamp = stamp_q;
`else
   assign stamp = '0;
`endif

   assign dump_en    = dump_en_q;
   assign ch_grant   = grant_q;
   assign ch_sel     = sel_q;
   assign sample_idx = idx_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
